// File: rtl/div_pkg.sv
// div_pkg: Q6.10 format constants, scheduler states and a saturating magnitude helper
package div_pkg;
  localparam int W = 16;
  localparam int FRAC = 10;
  localparam int MIN_MSB = 2 * FRAC - W + 1;
  localparam logic [W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [W-1:0] Q_MIN_SAT = 16'h8001;
  localparam logic [W-1:0] Q_NEG = {1'b1, {(W - 1){1'b0}}};
  typedef enum logic [2:0] {IDLE, LOAD, ITER, DONE, ERR} state_e;
  function automatic logic [W-1:0] q_abs(input logic [W-1:0] v);
    return v[W-1] ? (v == Q_NEG ? Q_MAX : -v) : v;
  endfunction
endpackage

// File: rtl/div_scheduler_if.sv
// div_scheduler_if: requester-side request/response bundle of the divider scheduler
interface div_scheduler_if
  import div_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_nr;
  logic [N_REQ*W-1:0] req_dr;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_res;
  logic               rsp_err;
  modport master (output req_valid, req_nr, req_dr, input req_ready, rsp_valid, rsp_res, rsp_err);
  modport slave (input req_valid, req_nr, req_dr, output req_ready, rsp_valid, rsp_res, rsp_err);
endinterface

// File: rtl/div_seed.sv
// div_seed: Newton-Raphson seed 2^(2*FRAC-1-m) from the MSB index m of |dr|, err when it cannot fit
module div_seed
  import div_pkg::*;
(
  input  logic [W-1:0] dr_abs,
  output logic [W-1:0] guess,
  output logic         seed_err
);
  always_comb begin
    guess = '0;
    seed_err = 1'b1;
    for (int i = MIN_MSB; i < W - 1; i++) begin
      if (dr_abs[i]) begin
        guess = W'(1) << (2 * FRAC - 1 - i);
        seed_err = 1'b0;
      end
    end
  end
endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: round-robin sharing of one Newton-Raphson divider with seed generation and sign fix-up
module div_scheduler
  import div_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int ITER_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst,
  div_scheduler_if.slave bus,
  output logic           busy,
  output logic           div_load,
  output logic [W-1:0]   div_nr,
  output logic [W-1:0]   div_dr,
  output logic [W-1:0]   div_guess,
  input  logic [W-1:0]   div_res
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2((LOAD_CYCLES > ITER_CYCLES ? LOAD_CYCLES : ITER_CYCLES) + 1);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, gnt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] nr_q, nr_d, dr_q, dr_d, guess_q, guess_d;
  logic [W-1:0] sel_nr, sel_dr, dr_abs, guess;
  logic sign_q, sign_d, found, seed_err;
  int j;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    j = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      j = j >= N_REQ ? j - N_REQ : j;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        gnt = IW'(j);
      end
    end
  end
  assign sel_nr = bus.req_nr[gnt*W +: W];
  assign sel_dr = bus.req_dr[gnt*W +: W];
  assign dr_abs = q_abs(sel_dr);
  div_seed u_seed (.dr_abs(dr_abs), .guess(guess), .seed_err(seed_err));
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    sign_d = sign_q;
    nr_d = nr_q;
    dr_d = dr_q;
    guess_d = guess_q;
    cnt_d = cnt_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_res = '0;
    bus.rsp_err = 1'b0;
    div_load = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        bus.req_ready = N_REQ'(1) << gnt;
        ptr_d = gnt == IW'(N_REQ - 1) ? '0 : gnt + 1'b1;
        idx_d = gnt;
        sign_d = sel_nr[W-1] ^ sel_dr[W-1];
        nr_d = q_abs(sel_nr);
        dr_d = dr_abs;
        guess_d = guess;
        cnt_d = '0;
        state_d = seed_err ? ERR : LOAD;
      end
      LOAD: begin
        div_load = 1'b1;
        cnt_d = cnt_q == CW'(LOAD_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(LOAD_CYCLES - 1) ? ITER : LOAD;
      end
      ITER: begin
        cnt_d = cnt_q == CW'(ITER_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(ITER_CYCLES - 1) ? DONE : ITER;
      end
      DONE: begin
        bus.rsp_valid = N_REQ'(1) << idx_q;
        bus.rsp_res = !sign_q ? div_res : div_res == Q_NEG ? Q_MAX : -div_res;
        state_d = IDLE;
      end
      ERR: begin
        bus.rsp_valid = N_REQ'(1) << idx_q;
        bus.rsp_err = 1'b1;
        bus.rsp_res = sign_q ? Q_MIN_SAT : Q_MAX;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign div_nr = state_q inside {LOAD, ITER} ? nr_q : '0;
  assign div_dr = state_q inside {LOAD, ITER} ? dr_q : '0;
  assign div_guess = state_q inside {LOAD, ITER} ? guess_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      sign_q <= 1'b0;
      nr_q <= '0;
      dr_q <= '0;
      guess_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      sign_q <= sign_d;
      nr_q <= nr_d;
      dr_q <= dr_d;
      guess_q <= guess_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: randomized and directed bench with a transaction-level model and a timed divider stand-in
module tb_div_scheduler;
  import div_pkg::*;
  localparam int N = 4, LC = 2, IC = 8, LAT = LC + IC + 1;
  typedef struct {
    int idx;
    int acc;
    bit err;
    logic [15:0] nr, dr, res, guess;
  } job_t;
  logic clk = 1'b0, rst = 1'b1, rst_seen = 1'b0;
  logic busy, div_load;
  logic [15:0] div_nr, div_dr, div_guess, div_res;
  int cyc = 0, checks = 0, errors = 0;
  div_scheduler_if #(.N_REQ(N)) bus ();
  div_scheduler #(.N_REQ(N), .LOAD_CYCLES(LC), .ITER_CYCLES(IC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .div_load(div_load),
    .div_nr(div_nr), .div_dr(div_dr), .div_guess(div_guess), .div_res(div_res)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_seen <= rst;
  end
  // divider stand-in: latches on load, shows the exact quotient only after IC low cycles
  logic [15:0] fd_nr = '0, fd_dr = '0;
  int fd_cnt = 0;
  always @(posedge clk) begin
    if (div_load) begin
      fd_nr <= div_nr;
      fd_dr <= div_dr;
      fd_cnt <= 0;
    end else if (fd_cnt < 1000) fd_cnt <= fd_cnt + 1;
  end
  always_comb div_res = (fd_cnt >= IC && fd_dr != 0) ? 16'((32'(fd_nr) << 10) / 32'(fd_dr)) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic chk_near(input string name, input logic [15:0] act, input logic [15:0] exp);
    logic [15:0] d;
    d = act - exp;
    checks++;
    if ($signed(d) > 2 || $signed(d) < -2) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h +-2", name, act, exp);
    end
  endtask
  function automatic int sabs(input logic [15:0] v);
    return v == 16'h8000 ? 32'h7FFF : v[15] ? 65536 - int'(v) : int'(v);
  endfunction
  function automatic job_t predict(input int idx, input logic [15:0] nr, input logic [15:0] dr, input int c);
    job_t jb;
    int an, ad, m, q;
    bit s;
    an = sabs(nr);
    ad = sabs(dr);
    m = -1;
    for (int v = ad; v > 0; v = v >> 1) m++;
    s = nr[15] ^ dr[15];
    jb.idx = idx;
    jb.acc = c;
    jb.nr = 16'(an);
    jb.dr = 16'(ad);
    jb.err = m < 5;
    jb.guess = jb.err ? 16'h0 : 16'(1 << (19 - m));
    q = jb.err ? 0 : ((an * 1024) / ad) & 32'hFFFF;
    jb.res = jb.err ? (s ? 16'h8001 : 16'h7FFF) : !s ? 16'(q) : q == 32'h8000 ? 16'h7FFF : 16'(65536 - q);
    return jb;
  endfunction

  job_t job;
  bit job_on = 1'b0;
  int free_at = 0, ptr = 0;
  always @(negedge clk) begin
    logic [N-1:0] exp_ready, exp_rv;
    bit idle;
    int g;
    if (rst_seen) begin
      job_on = 1'b0;
      ptr = 0;
      free_at = 0;
      chk("rst_busy", busy, 0);
      chk("rst_ctl", {bus.rsp_valid, bus.rsp_err, div_load}, 0);
      chk("rst_res_nr", {bus.rsp_res, div_nr}, 0);
      chk("rst_dr_guess", {div_dr, div_guess}, 0);
    end
    idle = !job_on || cyc >= free_at;
    exp_rv = (job_on && cyc == job.acc + (job.err ? 1 : LAT)) ? N'(1) << job.idx : '0;
    chk("busy", busy, !idle);
    chk("div_load", div_load, job_on && !job.err && cyc > job.acc && cyc <= job.acc + LC);
    chk("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv != 0) begin
      chk("rsp_res", bus.rsp_res, job.res);
      chk("rsp_err", bus.rsp_err, job.err);
    end
    if (job_on && !job.err && cyc > job.acc && cyc < job.acc + LAT) begin
      chk("div_nr", div_nr, job.nr);
      chk("div_dr", div_dr, job.dr);
      chk("div_guess", div_guess, job.guess);
    end
    exp_ready = '0;
    g = -1;
    if (idle)
      for (int k = 0; k < N; k++)
        if (g < 0 && bus.req_valid[(ptr + k) % N]) g = (ptr + k) % N;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_ready);
    if (g >= 0 && !rst) begin
      job = predict(g, bus.req_nr[g*W +: W], bus.req_dr[g*W +: W], cyc);
      job_on = 1'b1;
      free_at = cyc + (job.err ? 2 : LAT + 1);
      ptr = (g + 1) % N;
    end
  end

  task automatic run_job(input int idx, input logic [15:0] nr, input logic [15:0] dr, input bit e,
                         input logic [15:0] r, input logic [15:0] gs, input string nm);
    int t, lat, loads;
    logic [15:0] g;
    @(posedge clk);
    #2;
    bus.req_nr[idx*W +: W] = nr;
    bus.req_dr[idx*W +: W] = dr;
    bus.req_valid[idx] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[idx] && t < 40);
    chk({nm, "_accept"}, bus.req_ready[idx], 1);
    @(posedge clk);
    #2 bus.req_valid[idx] = 1'b0;
    lat = 0;
    loads = 0;
    g = '0;
    do begin
      @(negedge clk);
      lat++;
      if (div_load) begin
        loads++;
        g = div_guess;
      end
    end while (!bus.rsp_valid[idx] && lat < 40);
    chk({nm, "_latency"}, lat, e ? 1 : 11);
    chk({nm, "_err"}, bus.rsp_err, e);
    chk({nm, "_loads"}, loads, e ? 0 : 2);
    chk_near({nm, "_res"}, bus.rsp_res, r);
    if (!e) chk({nm, "_guess"}, g, gs);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  function automatic logic [15:0] rnd_nr();
    logic [15:0] v;
    v = 16'($urandom_range(0, 65535));
    return v == 16'h8000 ? 16'h0 : v;
  endfunction
  function automatic logic [15:0] rnd_dr();
    int r;
    r = $urandom_range(0, 9);
    return r == 0 ? 16'h0 : r == 1 ? 16'($urandom_range(1, 31)) : r == 2 ? 16'h8000 : 16'($urandom_range(1, 65535));
  endfunction

  initial begin
    int order[8];
    int n, t, seen;
    logic [N-1:0] acc;
    bus.req_valid = '0;
    bus.req_nr = '0;
    bus.req_dr = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    run_job(0, 16'h3C00, 16'h5C00, 0, 16'h029C, 16'h0020, "q15_23");
    run_job(2, 16'h1C00, 16'h3400, 0, 16'h0227, 16'h0040, "q7_13");
    run_job(1, 16'hC400, 16'h5C00, 0, 16'hFD64, 16'h0020, "neg_nr");
    run_job(3, 16'hC400, 16'hA400, 0, 16'h029C, 16'h0020, "neg_both");
    run_job(2, 16'h3C00, 16'h8000, 0, 16'hFE20, 16'h0020, "dr_most_neg");
    run_job(1, 16'h0100, 16'h0020, 0, 16'h2000, 16'h4000, "msb5");
    run_job(0, 16'h3C00, 16'h0000, 1, 16'h7FFF, 16'h0, "dr_zero");
    run_job(1, 16'h3C00, 16'h0010, 1, 16'h7FFF, 16'h0, "dr_small");
    run_job(3, 16'hC400, 16'h0000, 1, 16'h8001, 16'h0, "err_neg");
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_nr[i*W +: W] = 16'h3C00 + 16'(i);
      bus.req_dr[i*W +: W] = 16'h5C00;
    end
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) order[k] = -1;
    n = 0;
    t = 0;
    while (n < 8 && t < 400) begin
      @(negedge clk);
      t++;
      for (int k = 0; k < N; k++)
        if (bus.req_ready[k] && bus.req_valid[k] && n < 8) begin
          order[n] = k;
          n++;
        end
    end
    @(posedge clk);
    #2 bus.req_valid = '0;
    for (int k = 0; k < 8; k++) chk("grant_order", order[k], k % 4);
    repeat (15) @(posedge clk);
    #2;
    bus.req_nr[2*W +: W] = 16'h1C00;
    bus.req_dr[2*W +: W] = 16'h3400;
    bus.req_valid[2] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[2] && t < 40);
    chk("midrst_accept", bus.req_ready[2], 1);
    @(posedge clk);
    #2 bus.req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_outs", {bus.rsp_valid, div_load, div_guess}, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen += int'(bus.rsp_valid != 0);
    end
    chk("midrst_no_rsp", seen, 0);
    @(posedge clk);
    #2;
    bus.req_valid = 4'b1001;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.req_ready == 0 && t < 40);
    chk("midrst_ptr0", bus.req_ready, 4'b0001);
    @(posedge clk);
    #2 bus.req_valid = '0;
    repeat (15) @(posedge clk);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = $urandom_range(0, 99) < 40;
          bus.req_nr[i*W +: W] = rnd_nr();
          bus.req_dr[i*W +: W] = rnd_dr();
        end else if ($urandom_range(0, 99) < 3) bus.req_valid[i] = 1'b0;
      end
    end
    bus.req_valid = '0;
    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
